// File: rtl/syscall_io_dispatcher.sv
// Syscall I/O dispatcher: decodes acc into HALT or a per-channel
// read/write and runs a 4-phase req/ack handshake with optional timeout.
module syscall_io_dispatcher #(
  parameter int WIDTH   = 16,
  parameter int NCHAN   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             runio,
  input  logic [WIDTH-1:0] acc,
  input  logic [NCHAN-1:0] ioack,
  output logic [NCHAN-1:0] io_req,
  output logic             io_we,
  output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] chan_sel,
  output logic             acc_write,
  output logic             iobusy,
  output logic             halted,
  output logic [1:0]       status
);

  localparam int CSW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [CW-1:0]    CNT_LAST = CW'(TLIM);
  localparam logic [CW-1:0]    CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] MAXCODE  = WIDTH'(2 * NCHAN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WACK = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
  localparam logic [2:0] S_WREL = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ILL = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [NCHAN-1:0] req_q, req_d;
  logic             we_q, we_d;
  logic [CSW-1:0]   chan_q, chan_d;
  logic [1:0]       status_q, status_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // acc-1 fits in CSW+1 bits for every legal code
  logic [CSW:0] k_lo;
  logic         legal;
  logic         ack_sel;
  logic         tmo_hit;

  assign k_lo    = acc[CSW:0] - (CSW + 1)'(1);
  assign legal   = (acc != '0) && (acc <= MAXCODE);
  assign ack_sel = ioack[chan_q];
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    chan_d   = chan_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (runio) begin
          if (acc == '0) begin
            state_d = S_HALT;
          end else if (legal) begin
            chan_d           = k_lo[CSW:1];
            we_d             = k_lo[0];
            req_d            = '0;
            req_d[k_lo[CSW:1]] = 1'b1;
            cnt_d            = '0;
            status_d         = ST_OK;
            state_d          = S_WACK;
          end else begin
            status_d = ST_ILL;
            state_d  = S_DONE;
          end
        end
      end
      S_WACK: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        // ack has priority over a coincident timeout
        if (ack_sel) begin
          req_d    = '0;
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (tmo_hit) begin
          req_d    = '0;
          status_d = ST_TMO;
          state_d  = S_DONE;
        end else if (!runio) begin
          req_d   = '0;
          state_d = S_WREL;
        end
      end
      S_DONE: state_d = S_WREL;
      S_WREL: if (!ack_sel) state_d = S_IDLE;
      S_HALT: req_d = '0;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      we_q     <= 1'b0;
      chan_q   <= '0;
      status_q <= ST_OK;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      chan_q   <= chan_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign io_req    = req_q;
  assign io_we     = we_q;
  assign chan_sel  = chan_q;
  assign status    = status_q;
  assign iobusy    = (state_q != S_DONE);
  assign halted    = (state_q == S_HALT);
  assign acc_write = (state_q == S_WACK) & runio & ~we_q & ack_sel;

endmodule

// File: tb/tb_syscall_io_dispatcher.sv
// Bench for syscall_io_dispatcher: directed scenarios plus randomized
// calls checked against a transaction-level model of the code map.
module tb_syscall_io_dispatcher;

  localparam int NCH = 4;
  localparam int TO  = 8;

  logic        clock;
  logic        reset;
  logic        runio;
  logic [15:0] acc;
  logic [3:0]  ioack;
  logic [3:0]  io_req;
  logic        io_we;
  logic [1:0]  chan_sel;
  logic        acc_write;
  logic        iobusy;
  logic        halted;
  logic [1:0]  status;

  int checks = 0;
  int errors = 0;

  syscall_io_dispatcher #(
    .WIDTH(16), .NCHAN(NCH), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .runio(runio),
    .acc(acc), .ioack(ioack), .io_req(io_req),
    .io_we(io_we), .chan_sel(chan_sel),
    .acc_write(acc_write), .iobusy(iobusy),
    .halted(halted), .status(status)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // One syscall: code, ack delay (cycles of io_req before ack), ack hold.
  task automatic run_call(input logic [15:0] code, input int d,
                          input int hold, input string nm);
    logic       legal;
    int         kk;
    logic [1:0] ch;
    logic       we;
    logic [3:0] oh;
    logic [1:0] st;
    logic       acked;
    int         e;
    legal = (code >= 1) && (code <= 2 * NCH);
    kk    = legal ? int'(code) - 1 : 0;
    ch    = 2'(kk / 2);
    we    = (kk % 2) == 1;
    oh    = legal ? 4'(1 << (kk / 2)) : 4'b0;
    acked = legal && (d < TO);
    st    = !legal ? 2'b01 : (acked ? 2'b00 : 2'b10);
    e     = acked ? d + 1 : TO;
    @(negedge clock);
    acc = code; runio = 1'b1; ioack = '0;
    if (legal) begin
      for (int c = 1; c <= e; c++) begin
        @(posedge clock); #1;
        checks++;
        if ({io_req, io_we, chan_sel, iobusy, status} !== {oh, we, ch, 1'b1, 2'b00}) begin
          errors++;
          $display("FAIL %s wait c=%0d req/we/sel/busy/st got %b exp %b", nm, c,
                   {io_req, io_we, chan_sel, iobusy, status}, {oh, we, ch, 1'b1, 2'b00});
        end
        @(negedge clock);
        acc = 16'($urandom);
        ioack = 4'($urandom) & ~oh;
        if (c == d + 1) ioack = ioack | oh;
        #1;
        checks++;
        if (acc_write !== ((c == d + 1) && !we)) begin
          errors++;
          $display("FAIL %s acc_write c=%0d got %b exp %b", nm, c, acc_write,
                   (c == d + 1) && !we);
        end
      end
    end
    @(posedge clock); #1;
    checks++;
    if ({io_req, iobusy, status, acc_write, halted} !== {4'b0, 1'b0, st, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s done req/busy/st/aw/halt got %b exp %b", nm,
               {io_req, iobusy, status, acc_write, halted}, {4'b0, 1'b0, st, 1'b0, 1'b0});
    end
    @(negedge clock);
    runio = 1'b0;
    acc = 16'($urandom);
    ioack = (acked && hold > 0) ? oh : 4'b0;
    for (int h = 0; h < ((acked && hold > 0) ? hold : 1); h++) begin
      @(posedge clock); #1;
      checks++;
      if ({io_req, iobusy, status, acc_write} !== {4'b0, 1'b1, st, 1'b0}) begin
        errors++;
        $display("FAIL %s release h=%0d req/busy/st/aw got %b exp %b", nm, h,
                 {io_req, iobusy, status, acc_write}, {4'b0, 1'b1, st, 1'b0});
      end
    end
    @(negedge clock);
    ioack = '0;
    @(posedge clock); #1;
    checks++;
    if ({io_req, iobusy, status} !== {4'b0, 1'b1, st}) begin
      errors++;
      $display("FAIL %s idle req/busy/st got %b exp %b", nm,
               {io_req, iobusy, status}, {4'b0, 1'b1, st});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; runio = 1'b0; acc = '0; ioack = '0;
    #12;
    checks++;
    if ({io_req, io_we, chan_sel, iobusy, halted, status, acc_write} !==
        {4'b0, 1'b0, 2'b0, 1'b1, 1'b0, 2'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset outputs got %b exp %b",
               {io_req, io_we, chan_sel, iobusy, halted, status, acc_write},
               {4'b0, 1'b0, 2'b0, 1'b1, 1'b0, 2'b0, 1'b0});
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({io_req, iobusy, halted} !== {4'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle got %b exp %b", {io_req, iobusy, halted}, {4'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_read();
    run_call(16'd3, 3, 1, "read_ch1");
    run_call(16'd1, 0, 0, "read_ch0_fast");
    run_call(16'd7, TO - 1, 2, "read_ch3_ack_at_timeout");
  endtask

  task automatic test_write();
    run_call(16'd8, 2, 3, "write_ch3");
    run_call(16'd2, 5, 0, "write_ch0");
  endtask

  task automatic test_illegal();
    run_call(16'd9, 0, 0, "illegal_9");
    run_call(16'hFFFF, 0, 0, "illegal_ffff");
  endtask

  task automatic test_timeout_late_ack();
    int n;
    run_call(16'd4, TO + 3, 0, "timeout_ch1");
    @(negedge clock);
    acc = 16'd1; runio = 1'b1; ioack = '0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (io_req == 4'b0) break;
      n++;
    end
    checks++;
    if ({n[7:0], iobusy, status} !== {8'd8, 1'b0, 2'b10}) begin
      errors++;
      $display("FAIL timeout_cycles cycles/busy/st got %0d %b %b exp 8 0 10",
               n, iobusy, status);
    end
    @(negedge clock);
    runio = 1'b0; ioack = 4'b0001;
    @(negedge clock);
    runio = 1'b1; acc = 16'd3;
    for (int h = 0; h < 3; h++) begin
      @(posedge clock); #1;
      checks++;
      if (io_req !== 4'b0) begin
        errors++;
        $display("FAIL late_ack_block h=%0d io_req got %b exp 0000", h, io_req);
      end
    end
    @(negedge clock);
    ioack = '0;
    @(posedge clock); #1;
    checks++;
    if (io_req !== 4'b0) begin
      errors++;
      $display("FAIL late_ack_release io_req got %b exp 0000", io_req);
    end
    @(posedge clock); #1;
    checks++;
    if ({io_req, io_we, status} !== {4'b0010, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL late_ack_redecode req/we/st got %b exp %b",
               {io_req, io_we, status}, {4'b0010, 1'b0, 2'b00});
    end
    @(negedge clock);
    ioack = 4'b0010;
    @(posedge clock); #1;
    checks++;
    if ({iobusy, status} !== 3'b000) begin
      errors++;
      $display("FAIL late_ack_done busy/st got %b exp 000", {iobusy, status});
    end
    @(negedge clock);
    runio = 1'b0; ioack = '0;
    @(posedge clock);
    @(posedge clock);
  endtask

  task automatic test_abort();
    @(negedge clock);
    acc = 16'd5; runio = 1'b1; ioack = '0;
    @(posedge clock);
    @(negedge clock);
    ioack = 4'b1011;
    #1;
    checks++;
    if ({io_req, acc_write} !== {4'b0100, 1'b0}) begin
      errors++;
      $display("FAIL other_ack_ignored req/aw got %b exp 01000", {io_req, acc_write});
    end
    @(posedge clock); #1;
    checks++;
    if ({io_req, iobusy, status} !== {4'b0100, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL other_ack_hold req/busy/st got %b exp 0100100",
               {io_req, iobusy, status});
    end
    @(negedge clock);
    runio = 1'b0; ioack = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({io_req, iobusy, status} !== {4'b0, 1'b1, 2'b00}) begin
        errors++;
        $display("FAIL abort i=%0d req/busy/st got %b exp 0000100", i,
                 {io_req, iobusy, status});
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    acc = 16'd6; runio = 1'b1; ioack = '0;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({io_req, io_we, chan_sel, iobusy, halted, status, acc_write} !==
        {4'b0, 1'b0, 2'b0, 1'b1, 1'b0, 2'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got %b exp %b",
               {io_req, io_we, chan_sel, iobusy, halted, status, acc_write},
               {4'b0, 1'b0, 2'b0, 1'b1, 1'b0, 2'b0, 1'b0});
    end
    runio = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({io_req, iobusy} !== {4'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_mid_after i=%0d req/busy got %b exp 00001", i,
                 {io_req, iobusy});
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] code;
    for (int i = 0; i < 30; i++) begin
      if (i % 7 == 6) code = 16'($urandom) | 16'h0100;
      else code = 16'($urandom_range(1, 2 * NCH + 3));
      run_call(code, int'($urandom_range(0, TO + 2)),
               int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_halt();
    @(negedge clock);
    acc = 16'd0; runio = 1'b1; ioack = '0;
    @(posedge clock); #1;
    checks++;
    if ({halted, io_req, iobusy} !== {1'b1, 4'b0, 1'b1}) begin
      errors++;
      $display("FAIL halt_enter halt/req/busy got %b exp 100001",
               {halted, io_req, iobusy});
    end
    @(negedge clock);
    runio = 1'b0;
    @(negedge clock);
    runio = 1'b1; acc = 16'd1; ioack = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({halted, io_req, iobusy, acc_write} !== {1'b1, 4'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL halt_stay i=%0d halt/req/busy/aw got %b exp 1000010", i,
                 {halted, io_req, iobusy, acc_write});
      end
    end
    runio = 1'b0; ioack = '0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset halted got %b exp 0", halted);
    end
    @(negedge clock);
    reset = 1'b1;
    run_call(16'd1, 1, 1, "after_halt");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_illegal();
    test_timeout_late_ack();
    test_abort();
    test_reset_mid();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
